// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and coordinate widths for the text-mode pixel path.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic HS_POL = 1'b0;
    localparam logic VS_POL = 1'b0;

    localparam int POS_X_W = 10;
    localparam int POS_Y_W = 9;
    localparam int CNT_W   = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    // Half-open window test used for the sync decodes.
    function automatic logic in_window(cnt_t val, cnt_t lo, cnt_t hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Clock-enabled register chain; DEPTH=0 collapses to a wire.
module sync_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_s;
            assign unused_s = ^{clk, rst_n, ce, rst_val};
            assign dout     = din;
        end else begin : g_chain
            logic [WIDTH-1:0] stage_r [DEPTH];

            // Shift the bundle one stage per pixel tick.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= rst_val;
                    end
                end else if (ce) begin
                    stage_r[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign dout = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates plus sync/blank delayed to match the glyph pipeline.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FP     = vga_timing_pkg::H_FP,
    parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int   H_BP     = vga_timing_pkg::H_BP,
    parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FP     = vga_timing_pkg::V_FP,
    parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int   V_BP     = vga_timing_pkg::V_BP,
    parameter logic HS_POL   = vga_timing_pkg::HS_POL,
    parameter logic VS_POL   = vga_timing_pkg::VS_POL,
    parameter int   PIPE_DLY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_ce,
    output logic [POS_X_W-1:0] posx,
    output logic [POS_Y_W-1:0] posy,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic               blank_n
);

    localparam cnt_t H_LAST   = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t H_ACT    = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT    = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    cnt_t hcnt_r;
    cnt_t vcnt_r;
    logic hs_raw_s;
    logic vs_raw_s;
    logic active_s;
    logic at_line_start_s;

    // Raster counters; the line counter steps only on a column wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_r <= 10'd0;
            vcnt_r <= 10'd0;
        end else if (pix_ce) begin
            if (hcnt_r == H_LAST) begin
                hcnt_r <= 10'd0;
                if (vcnt_r == V_LAST) begin
                    vcnt_r <= 10'd0;
                end else begin
                    vcnt_r <= vcnt_r + 10'd1;
                end
            end else begin
                hcnt_r <= hcnt_r + 10'd1;
            end
        end
    end

    assign active_s = (hcnt_r < H_ACT) && (vcnt_r < V_ACT);
    assign hs_raw_s = in_window(hcnt_r, HS_START, HS_END) ? HS_POL : ~HS_POL;
    assign vs_raw_s = in_window(vcnt_r, VS_START, VS_END) ? VS_POL : ~VS_POL;

    assign active = active_s;
    assign posx   = active_s ? hcnt_r : 10'd0;
    assign posy   = active_s ? vcnt_r[POS_Y_W-1:0] : 9'd0;

    // Counter leaves the origin column on this very tick, so pulses cannot stretch.
    assign at_line_start_s = pix_ce && (hcnt_r == 10'd0);
    assign line_start      = at_line_start_s;
    assign frame_start     = at_line_start_s && (vcnt_r == 10'd0);

    sync_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_DLY)
    ) u_sync_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (pix_ce),
        .rst_val ({~HS_POL, ~VS_POL, 1'b0}),
        .din     ({hs_raw_s, vs_raw_s, active_s}),
        .dout    ({hsync, vsync, blank_n})
    );

endmodule
